// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-slave SPI master with run-time CPOL/CPHA/bit order,
// programmable SCK divider and a TX FIFO feeding back-to-back frames.
module spi_master_mc #(
  parameter int DATA_W    = 8,
  parameter int NUM_SS    = 4,
  parameter int DIV_W     = 8,
  parameter int TXF_DEPTH = 4
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst,
  input  logic [DATA_W-1:0]         i_tx_data,
  input  logic                      i_tx_push,
  output logic                      o_tx_full,
  input  logic                      i_trans_en,
  input  logic                      i_cpol,
  input  logic                      i_cpha,
  input  logic                      i_lsb_first,
  input  logic [DIV_W-1:0]          i_clk_div,
  input  logic [$clog2(NUM_SS)-1:0] i_ss_sel,
  output logic [DATA_W-1:0]         o_rx_data,
  output logic                      o_rx_valid,
  input  logic                      i_rx_pop,
  output logic                      o_interrupt,
  input  logic                      i_irq_clr,
  output logic                      o_rx_ovf,
  output logic                      o_busy,
  output logic                      o_sck,
  output logic                      o_mosi,
  input  logic                      i_miso,
  output logic [NUM_SS-1:0]         o_ss_n
);
  localparam int AW   = $clog2(TXF_DEPTH);
  localparam int SS_W = $clog2(NUM_SS);
  localparam int EW   = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DESEL} state_t;
  state_t r_state, w_nxt;

  logic [DATA_W-1:0] r_mem [TXF_DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic [DIV_W-1:0]  r_cnt, r_div;
  logic [EW-1:0]     r_edge;
  logic [SS_W-1:0]   r_ss;
  logic r_cpha, r_lsb, r_sck, r_mosi, r_miso_q, r_rx_valid, r_ovf, r_irq;
  logic w_empty, w_push, w_pop, w_done, w_half, w_edge, w_sample, w_shift, w_out, w_act;

  assign w_empty   = r_wptr == r_rptr;
  assign o_tx_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push    = i_tx_push && !o_tx_full;

  always_ff @(posedge i_sys_clk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_tx_data;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst)
    if (!i_sys_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= r_wptr + (AW+1)'(w_push);
      r_rptr <= r_rptr + (AW+1)'(w_pop);
    end

  assign w_half   = r_cnt == r_div;
  assign w_edge   = (r_state == XFER) && w_half;
  // even edge index = leading edge; CPHA selects which parity samples
  assign w_sample = w_edge && (r_edge[0] == r_cpha);
  assign w_shift  = (w_edge && (r_edge[0] != r_cpha)) || (r_state == SETUP && r_cnt == '0 && !r_cpha);
  assign w_out    = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
  assign w_act    = r_state inside {SETUP, XFER, HOLD};

  always_ff @(posedge i_sys_clk or negedge i_sys_rst)
    if (!i_sys_rst) r_state <= IDLE;
    else            r_state <= w_nxt;

  always_comb begin
    w_nxt  = r_state;
    w_pop  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE:  if (i_trans_en && !w_empty) begin
               w_pop = 1'b1;
               w_nxt = SETUP;
             end
      SETUP: w_nxt = w_half ? XFER : SETUP;
      XFER:  w_nxt = (w_half && r_edge == LAST) ? HOLD : XFER;
      HOLD:  if (w_half) begin
               w_done = 1'b1;
               w_pop  = i_trans_en && !w_empty;
               w_nxt  = !w_pop ? IDLE : (i_ss_sel == r_ss) ? SETUP : DESEL;
             end
      DESEL: w_nxt = w_half ? SETUP : DESEL;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst)
    if (!i_sys_rst) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_cnt      <= '0;
      r_div      <= '0;
      r_edge     <= '0;
      r_ss       <= '0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_miso_q   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_miso_q <= i_miso;
      r_cnt    <= (r_state == IDLE || w_half) ? '0 : r_cnt + 1'b1;
      r_edge   <= (r_state != XFER) ? '0 : r_edge + EW'(w_half);
      if (w_pop) begin
        r_tx   <= r_mem[r_rptr[AW-1:0]];
        r_cpha <= i_cpha;
        r_lsb  <= i_lsb_first;
        r_div  <= i_clk_div;
        r_ss   <= i_ss_sel;
        r_sck  <= i_cpol;
      end else begin
        if (w_shift) begin
          r_mosi <= w_out;
          r_tx   <= r_lsb ? r_tx >> 1 : r_tx << 1;
        end
        if (w_edge) r_sck <= ~r_sck;
      end
      if (w_sample) r_rx <= r_lsb ? {r_miso_q, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], r_miso_q};
      if (w_done) r_rx_data <= r_rx;
      r_rx_valid <= w_done || (r_rx_valid && !i_rx_pop);
      r_ovf      <= (w_done && r_rx_valid && !i_rx_pop) || (r_ovf && !i_irq_clr);
      r_irq      <= w_done || (r_irq && !i_irq_clr);
    end

  for (genvar s = 0; s < NUM_SS; s++) begin : g_ss
    assign o_ss_n[s] = !(w_act && r_ss == SS_W'(s));
  end

  assign o_sck       = (r_state == IDLE) ? i_cpol : r_sck;
  assign o_mosi      = r_mosi;
  assign o_busy      = r_state != IDLE;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_ovf    = r_ovf;
  assign o_interrupt = r_irq;
endmodule
